// File: rtl/instructions.sv
// Shared opcode set for the instruction control unit family.
package instructions;

   localparam int unsigned OPC_W = 4;

   typedef enum logic [OPC_W-1:0] {
      NOPO = 4'h0,
      LD   = 4'h1,
      LDC  = 4'h2,
      AND  = 4'h3,
      ANDC = 4'h4,
      OR   = 4'h5,
      ORC  = 4'h6,
      XNOR = 4'h7,
      STO  = 4'h8,
      STOC = 4'h9,
      IEN  = 4'hA,
      OEN  = 4'hB,
      JMP  = 4'hC,
      RTN  = 4'hD,
      SKZ  = 4'hE,
      NOPF = 4'hF
   } instruction_t;

endpackage

// File: rtl/icu_ctx_stack.sv
// LIFO of saved {rr, ien, oen} contexts; the top of stack is always visible on dout.
module icu_ctx_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH+1:0] din,
   output logic [WIDTH+1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH+1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;

   assign full  = (ptr == PTR_W'(DEPTH));
   assign empty = (ptr == '0);
   assign dout  = mem[IDX_W'(ptr - PTR_W'(1))];

   // Pointer only; entries need no reset since an empty stack is never read.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + PTR_W'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full && !rst) begin
         mem[IDX_W'(ptr)] <= din;
      end
   end

endmodule

// File: rtl/icu_wide.sv
// WIDTH-bit instruction control unit. Define ICU_WIDE_CTX_STACK_EN to save and
// restore {rr, ien, oen} across JMP/RTN through a DEPTH-entry context stack.
module icu_wide
   import instructions::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  instruction_t     instruction,
   input  logic [WIDTH-1:0] data_in,
   output logic             write,
   output logic [WIDTH-1:0] data_out,
   output logic             jmp,
   output logic             rtn,
   output logic             flag_o,
   output logic             flag_f,
   output logic [WIDTH-1:0] rr_out,
   output logic             skip,
   output logic             stk_ovf,
   output logic             stk_unf
);

   typedef struct packed {
      logic [WIDTH-1:0] rr;
      logic             ien;
      logic             oen;
   } icu_ctx_t;

   if (WIDTH < 1 || DEPTH < 1) begin : g_param_check
      $error("icu_wide: WIDTH and DEPTH must be at least 1");
   end

   logic [WIDTH-1:0] rr, rr_n, dm, data_out_n;
   logic             ien, ien_n, oen, oen_n;
   logic             write_n, jmp_n, rtn_n, flag_o_n, flag_f_n, skip_n;

`ifdef ICU_WIDE_CTX_STACK_EN
   logic     push, pop, stk_full, stk_empty, ovf_n, unf_n;
   icu_ctx_t push_ctx, pop_ctx;

   assign push_ctx = '{rr: rr, ien: ien, oen: oen};

   icu_ctx_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ctx_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_ctx),
      .dout  (pop_ctx),
      .full  (stk_full),
      .empty (stk_empty)
   );
`endif

   // Decode and execute; a skipped slot leaves every register and pulse idle.
   always_comb begin
      dm         = data_in & {WIDTH{ien}};
      rr_n       = rr;
      ien_n      = ien;
      oen_n      = oen;
      data_out_n = data_out;
      write_n    = 1'b0;
      jmp_n      = 1'b0;
      rtn_n      = 1'b0;
      flag_o_n   = 1'b0;
      flag_f_n   = 1'b0;
      skip_n     = 1'b0;
`ifdef ICU_WIDE_CTX_STACK_EN
      push       = 1'b0;
      pop        = 1'b0;
      ovf_n      = stk_ovf;
      unf_n      = stk_unf;
`endif
      if (!skip) begin
         unique case (instruction)
            NOPO: flag_o_n = 1'b1;
            LD:   rr_n = dm;
            LDC:  rr_n = ~dm;
            AND:  rr_n = rr & dm;
            ANDC: rr_n = rr & ~dm;
            OR:   rr_n = rr | dm;
            ORC:  rr_n = rr | ~dm;
            XNOR: rr_n = rr ^ ~dm;
            STO: begin
               if (oen) begin
                  data_out_n = rr;
                  write_n    = 1'b1;
               end
            end
            STOC: begin
               if (oen) begin
                  data_out_n = ~rr;
                  write_n    = 1'b1;
               end
            end
            IEN:  ien_n = data_in[0];
            OEN:  oen_n = dm[0];
            JMP: begin
               jmp_n = 1'b1;
`ifdef ICU_WIDE_CTX_STACK_EN
               if (stk_full) ovf_n = 1'b1;
               else          push  = 1'b1;
`endif
            end
            RTN: begin
               rtn_n  = 1'b1;
               skip_n = 1'b1;
`ifdef ICU_WIDE_CTX_STACK_EN
               if (stk_empty) begin
                  unf_n = 1'b1;
               end else begin
                  pop   = 1'b1;
                  rr_n  = pop_ctx.rr;
                  ien_n = pop_ctx.ien;
                  oen_n = pop_ctx.oen;
               end
`endif
            end
            SKZ:  skip_n = (rr == '0);
            NOPF: flag_f_n = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr       <= '0;
         ien      <= 1'b0;
         oen      <= 1'b0;
         data_out <= '0;
         write    <= 1'b0;
         jmp      <= 1'b0;
         rtn      <= 1'b0;
         flag_o   <= 1'b0;
         flag_f   <= 1'b0;
         skip     <= 1'b0;
      end else begin
         rr       <= rr_n;
         ien      <= ien_n;
         oen      <= oen_n;
         data_out <= data_out_n;
         write    <= write_n;
         jmp      <= jmp_n;
         rtn      <= rtn_n;
         flag_o   <= flag_o_n;
         flag_f   <= flag_f_n;
         skip     <= skip_n;
      end
   end

`ifdef ICU_WIDE_CTX_STACK_EN
   // Sticky stack error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else begin
         stk_ovf <= ovf_n;
         stk_unf <= unf_n;
      end
   end
`else
   assign stk_ovf = 1'b0;
   assign stk_unf = 1'b0;
`endif

   assign rr_out = rr;

endmodule

// File: tb/tb_icu_wide.sv
// Directed self-checking bench for icu_wide; stack cases run when ICU_WIDE_CTX_STACK_EN is defined.
module tb_icu_wide;
   import instructions::*;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   instruction_t     instruction;
   logic [WIDTH-1:0] data_in;
   logic             write, jmp, rtn, flag_o, flag_f, skip, stk_ovf, stk_unf;
   logic [WIDTH-1:0] data_out, rr_out;

   int n_cmp = 0;
   int n_mis = 0;

   icu_wide #(.WIDTH(WIDTH), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .instruction (instruction),
      .data_in     (data_in),
      .write       (write),
      .data_out    (data_out),
      .jmp         (jmp),
      .rtn         (rtn),
      .flag_o      (flag_o),
      .flag_f      (flag_f),
      .rr_out      (rr_out),
      .skip        (skip),
      .stk_ovf     (stk_ovf),
      .stk_unf     (stk_unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one instruction at the falling edge, let it execute, sample just after.
   task automatic exec(input instruction_t op, input logic [WIDTH-1:0] d);
      @(negedge clk);
      instruction = op;
      data_in     = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      instruction = NOPF;
      data_in     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rr", 32'(rr_out), 32'h0);
      check("rst_dout", 32'(data_out), 32'h0);
      check("rst_pulses", 32'({write, jmp, rtn, flag_o, flag_f, skip}), 32'h0);
      check("rst_stk", 32'({stk_ovf, stk_unf}), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Basic load/store path
      exec(IEN, 8'h01);
      exec(OEN, 8'h01);
      exec(LD, 8'hA5);
      check("ld_rr", 32'(rr_out), 32'hA5);
      check("ld_nowrite", 32'(write), 32'h0);
      exec(STO, 8'h00);
      check("sto_dout", 32'(data_out), 32'hA5);
      check("sto_write", 32'(write), 32'h1);
      exec(NOPF, 8'h00);
      check("sto_write_1cyc", 32'(write), 32'h0);
      check("nopf_flag_f", 32'(flag_f), 32'h1);
      exec(NOPO, 8'h00);
      check("nopo_flags", 32'({flag_o, flag_f}), 32'h2);
      exec(STOC, 8'h00);
      check("stoc_dout", 32'(data_out), 32'h5A);
      exec(STO, 8'h00);
      check("b2b_write", 32'(write), 32'h1);
      check("b2b_dout", 32'(data_out), 32'hA5);

      // Logic ops against masked input
      exec(AND, 8'h0F);
      check("and_rr", 32'(rr_out), 32'h05);
      exec(OR, 8'h30);
      check("or_rr", 32'(rr_out), 32'h35);
      exec(ANDC, 8'h01);
      check("andc_rr", 32'(rr_out), 32'h34);
      exec(ORC, 8'hFE);
      check("orc_rr", 32'(rr_out), 32'h35);
      exec(XNOR, 8'h35);
      check("xnor_rr", 32'(rr_out), 32'hFF);

      // Input masking and output enable via masked bit
      exec(IEN, 8'h00);
      exec(LD, 8'hFF);
      check("mask_ld", 32'(rr_out), 32'h00);
      exec(LDC, 8'hFF);
      check("mask_ldc", 32'(rr_out), 32'hFF);
      exec(OEN, 8'h01);
      exec(STO, 8'h00);
      check("oen0_write", 32'(write), 32'h0);
      check("oen0_dout", 32'(data_out), 32'hA5);

      // Skip on zero
      exec(IEN, 8'h01);
      exec(OEN, 8'h01);
      exec(LD, 8'h00);
      exec(SKZ, 8'h00);
      check("skz_skip", 32'(skip), 32'h1);
      exec(LD, 8'h3C);
      check("skipped_ld_rr", 32'(rr_out), 32'h00);
      check("skip_clears", 32'(skip), 32'h0);
      exec(LD, 8'h0F);
      check("after_skip_ld", 32'(rr_out), 32'h0F);
      exec(LD, 8'h01);
      exec(SKZ, 8'h00);
      check("skz_nonzero", 32'(skip), 32'h0);
      exec(LD, 8'h00);
      exec(SKZ, 8'h00);
      exec(STO, 8'h00);
      check("skipped_sto_write", 32'(write), 32'h0);
      check("skipped_sto_dout", 32'(data_out), 32'hA5);

`ifdef ICU_WIDE_CTX_STACK_EN
      // Context save/restore
      exec(LD, 8'h55);
      exec(JMP, 8'h00);
      check("jmp_pulse", 32'(jmp), 32'h1);
      exec(LD, 8'h00);
      exec(IEN, 8'h00);
      exec(RTN, 8'h00);
      check("rtn_pulse", 32'({rtn, skip, jmp}), 32'h6);
      check("rtn_rr", 32'(rr_out), 32'h55);
      exec(LD, 8'h11);
      check("rtn_skipped", 32'(rr_out), 32'h55);
      exec(LD, 8'hFF);
      check("rtn_ien", 32'(rr_out), 32'hFF);
      exec(STO, 8'h00);
      check("rtn_oen", 32'({write, data_out}), 32'h1FF);

      // Overflow after DEPTH pushes, underflow on pop past empty
      for (int i = 1; i <= 5; i++) begin
         exec(LD, 8'(i));
         exec(JMP, 8'h00);
         if (i == 4) check("no_ovf_at_full", 32'(stk_ovf), 32'h0);
      end
      check("ovf_set", 32'(stk_ovf), 32'h1);
      for (int i = 4; i >= 1; i--) begin
         exec(RTN, 8'h00);
         check("pop_rr", 32'(rr_out), 32'(i));
         exec(NOPF, 8'h00);
      end
      check("no_unf_yet", 32'(stk_unf), 32'h0);
      exec(LD, 8'h99);
      exec(RTN, 8'h00);
      check("unf_rr_kept", 32'(rr_out), 32'h99);
      check("unf_flags", 32'({stk_ovf, stk_unf, rtn, skip}), 32'hF);
      exec(NOPF, 8'h00);
`else
      exec(LD, 8'h00);
      exec(JMP, 8'h00);
      check("jmp_pulse", 32'({jmp, rtn, skip}), 32'h4);
      exec(RTN, 8'h00);
      check("rtn_pulse", 32'({jmp, rtn, skip}), 32'h3);
      exec(SKZ, 8'h00);
      check("skz_in_skip", 32'({rtn, skip}), 32'h0);
      exec(LD, 8'h42);
      check("after_rtn_ld", 32'(rr_out), 32'h42);
      check("stk_tied", 32'({stk_ovf, stk_unf}), 32'h0);
`endif

      // Reset asserted in a skipped slot
      exec(LD, 8'h00);
      exec(SKZ, 8'h00);
      @(negedge clk);
      rst         = 1'b1;
      instruction = LD;
      data_in     = 8'h77;
      @(posedge clk);
      #1;
      check("rst_skip_rr", 32'(rr_out), 32'h0);
      check("rst_skip_outs", 32'({write, jmp, rtn, flag_o, flag_f, skip, stk_ovf, stk_unf}), 32'h0);
      check("rst_skip_dout", 32'(data_out), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      exec(LDC, 8'h00);
      check("post_rst_exec", 32'(rr_out), 32'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/icu_wide.md
# icu_wide

Parametrised successor to the 1-bit instruction control unit: the same 16-opcode `instruction_t` set executed on a WIDTH-bit result register. It adds an optional context stack that saves and restores RR/IEN/OEN across JMP/RTN. The block sits between the program sequencer, which supplies `instruction` and consumes jmp/rtn/flags, and the I/O data bus.

## Interface
- WIDTH, 8, data path and result register width (≥1)
- DEPTH, 4, context stack entries (≥1; used only with ICU_WIDE_CTX_STACK_EN)
- clk  in  1  single system clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- instruction  in  instruction_t  opcode for this cycle
- data_in  in  WIDTH  input bus, sampled with instruction
- write  out  1  one-cycle store strobe, registered
- data_out  out  WIDTH  output register
- jmp / rtn / flag_o / flag_f  out  1 each  one-cycle registered pulses
- rr_out  out  WIDTH  result register
- skip  out  1  current instruction is being skipped
- stk_ovf / stk_unf  out  1 each  sticky stack overflow / underflow

## Operation
- Masked input: dm = data_in & {WIDTH{ien}}.
- LD: RR=dm. LDC: RR=~dm. AND/ANDC/OR/ORC: RR op dm or RR op ~dm. XNOR: RR=RR ^ ~dm, bitwise.
- IEN: ien=data_in[0], unmasked. OEN: oen=dm[0].
- STO/STOC with oen=1: data_out=RR or ~RR; write=1 next cycle. With oen=0 the store is a no-op and write stays 0.
- SKZ: skip=1 when RR==0, meaning all bits zero.
- RTN: rtn pulse and skip=1 unconditionally.
- JMP: jmp pulse. NOPO: flag_o pulse. NOPF: flag_f pulse.
- Skipped slot: the instruction is fully ignored. No state change, no pulses, no stack op. skip then clears, so at most one slot is skipped per set.
- Skip is never set by an instruction in a skipped slot.
- Reset values: RR, ien, oen, data_out, write, all pulses, skip, stack pointer, stk_ovf and stk_unf all 0.

## Timing
- Single edge: instruction and data_in are sampled at a posedge. RR, ien, oen and data_out update at that edge.
- write, jmp, rtn, flag_o and flag_f are high for exactly the cycle after the executing edge. Latency is 1.
- skip goes high the cycle after SKZ/RTN and covers exactly the next instruction.
- Back-to-back STO: write stays high continuously and data_out updates every cycle.
- rst high at an edge overrides any instruction. All outputs are reset the following cycle, and any pending skip and the stack contents are discarded.

## Configuration
- ICU_WIDE_CTX_STACK_EN defined:
  - JMP pushes {RR, ien, oen}.
  - RTN pops and restores the triple at the same edge the rtn pulse is scheduled.
  - Push when full: entry dropped, stk_ovf set.
  - Pop when empty: registers unchanged, stk_unf set.
  - stk_ovf/stk_unf clear only on rst.
- ICU_WIDE_CTX_STACK_EN undefined:
  - No storage; JMP/RTN only pulse.
  - stk_ovf and stk_unf are tied 0.
  - DEPTH is ignored.

## Structure
- Package `instructions` keeps `instruction_t`. Add `icu_ctx_t` (packed struct: rr, ien, oen), parametrised by width through the WIDTH of the instantiating module, or kept WIDTH-generic via a typedef in the module.
- Sub-module `icu_ctx_stack`: parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty. Push and pop are mutually exclusive by construction. Instantiated only under the macro.

## Test plan
- Reset then IEN data_in[0]=1, OEN 1, LD 0xA5, STO -> data_out=0xA5 and write=1 for one cycle, exactly one cycle after STO.
- ien=0, LD 0xFF -> RR=0x00. Then LDC 0xFF -> RR=0xFF. Then OEN 1 -> oen=0, so STO gives write=0.
- RR=0x00, SKZ, LD 0x3C, LD 0x0F -> the first LD is skipped (skip=1 that cycle) and RR=0x0F. With RR=0x01, SKZ -> no skip.
- Macro on: RR=0x55, ien=1, oen=1, JMP, LD 0x00, IEN 0, RTN -> rtn pulse, RR=0x55, ien=1, oen=1, next instruction skipped.
- Macro on, DEPTH=4: five JMPs -> stk_ovf=1 after the fifth. Five RTNs -> the fifth pop leaves RR unchanged and sets stk_unf=1.
- SKZ with RR=0 followed by rst asserted in the skipped slot -> all outputs 0 the next cycle, and the first instruction after rst deasserts executes normally.
